// File: rtl/mips_pkg.sv
// mips_pkg
// Shared constants for the multicycle MIPS datapath: next-PC select
// encodings, main opcode values decoded by control_unit, and the default
// reset vector used by the fetch stage.
package mips_pkg;

  // Next-PC select (PCSrc). Encoding 2'b11 is reserved and holds the PC.
  localparam logic [1:0] PCSRC_ALU      = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT   = 2'b01;
  localparam logic [1:0] PCSRC_JUMP     = 2'b10;
  localparam logic [1:0] PCSRC_RESERVED = 2'b11;

  // Main opcodes, Instr[31:26].
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Default reset vector.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/flopenr.sv
// flopenr
// Enable flip-flop with asynchronous active-high reset to a configurable
// value. Used for the program counter and the instruction register.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high; forces q to RESET_VAL
//   en    - load d on the rising edge when high, otherwise hold
//   d     - data in
//   q     - registered data out
module flopenr #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_ir_unit.sv
// fetch_ir_unit
// Program-counter / instruction-register stage of the multicycle MIPS
// datapath. Holds PC, IR, the memory data register and a count of IR loads,
// selects the memory address, and feeds opcode/funct to control_unit.
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-high reset
//   IRWrite             - load IR from ReadData
//   PCWrite             - unconditional PC write
//   BranchEQ, BranchNE  - conditional PC write on Zero / not Zero
//   IorD                - memory address select (0 = PC, 1 = ALUOut)
//   PCSrc               - next-PC select (ALU, ALUOut, jump, reserved)
//   Zero                - ALU zero flag for the current cycle
//   ALUResult, ALUOut   - combinational and registered ALU results
//   ReadData            - memory read data
//   Adr                 - memory address
//   PC, Instr, Data     - program counter, instruction reg, memory data reg
//   opcode, funct       - Instr[31:26] and Instr[5:0]
//   fetch_count         - number of IR loads since reset (wraps)
//   pc_misaligned       - sticky: PC was written with nonzero low bits
module fetch_ir_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT[WIDTH-1:0]
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             IRWrite,
  input  logic             PCWrite,
  input  logic             BranchEQ,
  input  logic             BranchNE,
  input  logic             IorD,
  input  logic [1:0]       PCSrc,
  input  logic             Zero,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic [WIDTH-1:0] ReadData,
  output logic [WIDTH-1:0] Adr,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] Instr,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic [WIDTH-1:0] Data,
  output logic [31:0]      fetch_count,
  output logic             pc_misaligned
);

  logic             pc_en;
  logic             pc_load;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] jump_target;

  // BranchEQ and BranchNE together make the write unconditional, which is
  // a legal combination and deliberately not flagged.
  assign pc_en = PCWrite | (BranchEQ & Zero) | (BranchNE & ~Zero);

  // Jump target is formed from the PC and IR as they stand before the edge,
  // so a simultaneous IR load never forwards into the jump.
  assign jump_target = {PC[WIDTH-1:28], Instr[25:0], 2'b00};

  always_comb begin
    pc_next = PC;
    unique case (PCSrc)
      PCSRC_ALU:      pc_next = ALUResult;
      PCSRC_ALUOUT:   pc_next = ALUOut;
      PCSRC_JUMP:     pc_next = jump_target;
      PCSRC_RESERVED: pc_next = PC;
      default:        pc_next = PC;
    endcase
  end

  // The reserved select suppresses the write entirely, so it can neither
  // move the PC nor raise the misalignment flag.
  assign pc_load = pc_en & (PCSrc != PCSRC_RESERVED);

  flopenr #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clock (clock),
    .reset (reset),
    .en    (pc_load),
    .d     (pc_next),
    .q     (PC)
  );

  flopenr #(
    .WIDTH     (WIDTH),
    .RESET_VAL ('0)
  ) u_ir (
    .clock (clock),
    .reset (reset),
    .en    (IRWrite),
    .d     (ReadData),
    .q     (Instr)
  );

  // Memory data register captures every cycle; the control sequence decides
  // when its contents are meaningful.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Data <= '0;
    end else begin
      Data <= ReadData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (IRWrite) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  // Sticky until reset; the misaligned value is still written to the PC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_misaligned <= 1'b0;
    end else if (pc_load && (pc_next[1:0] != 2'b00)) begin
      pc_misaligned <= 1'b1;
    end
  end

  assign Adr    = IorD ? ALUOut : PC;
  assign opcode = Instr[31:26];
  assign funct  = Instr[5:0];

endmodule

// File: tb/tb_fetch_ir_unit.sv
// tb_fetch_ir_unit
// Directed testbench for fetch_ir_unit with hand-computed expected values.
module tb_fetch_ir_unit;
  import mips_pkg::*;

  logic        clock;
  logic        reset;
  logic        IRWrite;
  logic        PCWrite;
  logic        BranchEQ;
  logic        BranchNE;
  logic        IorD;
  logic [1:0]  PCSrc;
  logic        Zero;
  logic [31:0] ALUResult;
  logic [31:0] ALUOut;
  logic [31:0] ReadData;
  logic [31:0] Adr;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] Data;
  logic [31:0] fetch_count;
  logic        pc_misaligned;

  int checks   = 0;
  int failures = 0;

  fetch_ir_unit #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .IRWrite       (IRWrite),
    .PCWrite       (PCWrite),
    .BranchEQ      (BranchEQ),
    .BranchNE      (BranchNE),
    .IorD          (IorD),
    .PCSrc         (PCSrc),
    .Zero          (Zero),
    .ALUResult     (ALUResult),
    .ALUOut        (ALUOut),
    .ReadData      (ReadData),
    .Adr           (Adr),
    .PC            (PC),
    .Instr         (Instr),
    .opcode        (opcode),
    .funct         (funct),
    .Data          (Data),
    .fetch_count   (fetch_count),
    .pc_misaligned (pc_misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", tag, act, exp);
    end else begin
      $display("ok   %s value=%08h", tag, act);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_controls();
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    BranchEQ = 1'b0;
    BranchNE = 1'b0;
    IorD     = 1'b0;
    PCSrc    = PCSRC_ALU;
    Zero     = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    idle_controls();
    ALUResult = '0;
    ALUOut    = '0;
    ReadData  = '0;

    // Reset held 12 ns, released between edges.
    #12;
    reset = 1'b0;
    #1;
    check("rst_pc",      PC, 32'h0);
    check("rst_instr",   Instr, 32'h0);
    check("rst_opcode",  {26'b0, opcode}, 32'h0);
    check("rst_count",   fetch_count, 32'h0);
    check("rst_adr",     Adr, 32'h0);
    check("rst_data",    Data, 32'h0);
    check("rst_misalgn", {31'b0, pc_misaligned}, 32'h0);

    // Fetch lw: IR and PC load on the same edge.
    ReadData  = 32'h8C08_0004;
    IRWrite   = 1'b1;
    PCWrite   = 1'b1;
    PCSrc     = PCSRC_ALU;
    ALUResult = 32'h4;
    step();
    check("fetch_instr",  Instr, 32'h8C08_0004);
    check("fetch_opcode", {26'b0, opcode}, {26'b0, OP_LW});
    check("fetch_funct",  {26'b0, funct}, 32'h4);
    check("fetch_pc",     PC, 32'h4);
    check("fetch_count",  fetch_count, 32'h1);
    check("fetch_data",   Data, 32'h8C08_0004);

    // beq not taken; Data still loads while IR holds.
    idle_controls();
    ReadData = 32'hDEAD_BEEF;
    BranchEQ = 1'b1;
    PCSrc    = PCSRC_ALUOUT;
    ALUOut   = 32'h20;
    Zero     = 1'b0;
    step();
    check("beq_nt_pc",    PC, 32'h4);
    check("data_uncond",  Data, 32'hDEAD_BEEF);
    check("ir_hold",      Instr, 32'h8C08_0004);
    check("count_hold",   fetch_count, 32'h1);

    Zero = 1'b1;
    step();
    check("beq_t_pc", PC, 32'h20);

    // bne: taken only when Zero = 0.
    BranchEQ = 1'b0;
    BranchNE = 1'b1;
    ALUOut   = 32'h30;
    Zero     = 1'b1;
    step();
    check("bne_nt_pc", PC, 32'h20);
    Zero = 1'b0;
    step();
    check("bne_t_pc", PC, 32'h30);

    // Both branch enables: unconditional, no flag.
    BranchEQ = 1'b1;
    BranchNE = 1'b1;
    ALUOut   = 32'h40;
    Zero     = 1'b1;
    step();
    check("both_br_pc",     PC, 32'h40);
    check("both_br_misalg", {31'b0, pc_misaligned}, 32'h0);

    // Reserved select holds PC even with an odd candidate and PCWrite.
    idle_controls();
    PCWrite   = 1'b1;
    PCSrc     = PCSRC_RESERVED;
    ALUResult = 32'h7;
    ALUOut    = 32'h7;
    step();
    check("rsv_pc",     PC, 32'h40);
    check("rsv_misalg", {31'b0, pc_misaligned}, 32'h0);

    // Set up PC = 1000_0004 and IR = j 0x10 on one edge.
    idle_controls();
    PCWrite   = 1'b1;
    PCSrc     = PCSRC_ALU;
    ALUResult = 32'h1000_0004;
    IRWrite   = 1'b1;
    ReadData  = 32'h0800_0010;
    step();
    check("jset_pc",     PC, 32'h1000_0004);
    check("jset_opcode", {26'b0, opcode}, {26'b0, OP_J});
    check("jset_count",  fetch_count, 32'h2);

    // Jump while a new instruction loads: target uses the old IR.
    PCSrc    = PCSRC_JUMP;
    ReadData = 32'h014B_4820;
    step();
    check("jump_pc",    PC, 32'h1000_0040);
    check("jump_instr", Instr, 32'h014B_4820);
    check("jump_funct", {26'b0, funct}, 32'h20);
    check("jump_count", fetch_count, 32'h3);

    // Address select is combinational.
    idle_controls();
    IorD   = 1'b1;
    ALUOut = 32'h44;
    #1;
    check("adr_aluout", Adr, 32'h44);
    IorD = 1'b0;
    #1;
    check("adr_pc", Adr, 32'h1000_0040);

    // Misaligned write: PC still written, flag sticks.
    PCWrite   = 1'b1;
    PCSrc     = PCSRC_ALU;
    ALUResult = 32'h6;
    step();
    check("misalg_pc",   PC, 32'h6);
    check("misalg_set",  {31'b0, pc_misaligned}, 32'h1);
    ALUResult = 32'h8;
    step();
    check("misalg_pc2",  PC, 32'h8);
    check("misalg_stky", {31'b0, pc_misaligned}, 32'h1);

    // Fetch, then reset between edges.
    idle_controls();
    IRWrite  = 1'b1;
    ReadData = 32'hAC09_0008;
    step();
    check("pre_rst_count", fetch_count, 32'h4);
    check("pre_rst_data",  Data, 32'hAC09_0008);
    check("pre_rst_op",    {26'b0, opcode}, {26'b0, OP_SW});
    idle_controls();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_pc",     PC, 32'h0);
    check("mid_rst_instr",  Instr, 32'h0);
    check("mid_rst_data",   Data, 32'h0);
    check("mid_rst_count",  fetch_count, 32'h0);
    check("mid_rst_misalg", {31'b0, pc_misaligned}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ir_unit.md
Name: fetch_ir_unit

Overview:
- Program-counter and instruction-register stage of the multicycle MIPS datapath.
- Drives the opcode/funct inputs of control_unit from the latched instruction.
- Consumes control_unit's IRWrite, PCWrite, BranchEQ, BranchNE, IorD and PCSrc to update PC and IR and to select the memory address.
- Also holds the memory data register and a retired-fetch counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
WIDTH, 32, datapath and address width.

Ports:
clock  in  1  system clock, rising edge active.
reset  in  1  asynchronous, active-high reset.
IRWrite  in  1  load IR from ReadData.
PCWrite  in  1  unconditional PC write.
BranchEQ  in  1  PC write if Zero.
BranchNE  in  1  PC write if not Zero.
IorD  in  1  address select: 0 = PC, 1 = ALUOut.
PCSrc  in  2  next-PC select.
Zero  in  1  ALU zero flag (current cycle).
ALUResult  in  WIDTH  combinational ALU result.
ALUOut  in  WIDTH  registered ALU result.
ReadData  in  WIDTH  memory read data.
Adr  out  WIDTH  memory address.
PC  out  WIDTH  current PC.
Instr  out  WIDTH  instruction register.
opcode  out  6  Instr[31:26], to control_unit.
funct  out  6  Instr[5:0], to control_unit.
Data  out  WIDTH  memory data register.
fetch_count  out  32  number of IR loads since reset.
pc_misaligned  out  1  sticky: PC was written with nonzero bits [1:0].

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, including mid-instruction):
  - PC = RESET_PC.
  - Instr = 0, so opcode = 0 and funct = 0.
  - Data = 0, fetch_count = 0, pc_misaligned = 0.
- PCEn = PCWrite | (BranchEQ & Zero) | (BranchNE & ~Zero), evaluated combinationally in the same cycle.
- Next PC, selected by PCSrc:
  - 00: ALUResult.
  - 01: ALUOut.
  - 10: jump target {PC[31:28], Instr[25:0], 2'b00}.
  - 11: reserved; PC holds even if PCEn = 1, no flag set.
- PC updates on the rising clock edge when PCEn = 1 and PCSrc != 11.
- Jump target always uses the pre-edge Instr and PC. When IRWrite and PCWrite are both high, IR and PC update on the same edge from old values, with no forwarding.
- IR loads ReadData on the rising edge when IRWrite = 1; otherwise it holds.
- Data loads ReadData on every rising edge (unconditional).
- Adr = IorD ? ALUOut : PC, purely combinational, zero latency.
- opcode and funct are combinational slices of Instr, so control_unit sees the new opcode one cycle after the IRWrite cycle.
- fetch_count:
  - Increments by 1 on each edge with IRWrite = 1.
  - Wraps 32'hFFFF_FFFF -> 0.
- pc_misaligned:
  - Set on an edge where the PC is written with next-PC[1:0] != 00. The PC is still written.
  - Cleared only by reset.
- BranchEQ and BranchNE both high: PCEn = 1 regardless of Zero. This is legal and must not be flagged.
- X on control inputs is not filtered; the bench must drive known values after reset.

Decomposition:
- Shared package mips_pkg:
  - PCSrc encoding constants: PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10.
  - Opcode constants: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
  - RESET_PC default.
- One sub-module, flopenr: a WIDTH-parameterised enable flip-flop with asynchronous active-high reset and a reset-value parameter. Instantiated for PC and IR.

Test Plan:
- Reset: assert reset for 12 ns, then release -> PC = 0, Instr = 0, opcode = 000000, fetch_count = 0, Adr = 0 with IorD = 0.
- Fetch: ReadData = 32'h8C08_0004 (lw), IRWrite = 1, PCWrite = 1, PCSrc = 00, ALUResult = 4, one edge -> Instr = 8C080004, opcode = 100011, PC = 4, fetch_count = 1.
- Branch: BranchEQ = 1, PCSrc = 01, ALUOut = 32'h20.
  - Zero = 0 -> PC unchanged.
  - Zero = 1 -> PC = 32'h20.
  - Repeat with BranchNE: taken only when Zero = 0.
- Jump: PC = 32'h1000_0004, Instr = 32'h0800_0010 (j), PCSrc = 10, PCWrite = 1 -> PC = 32'h1000_0040.
- Address/flag: IorD = 1, ALUOut = 32'h44 -> Adr = 32'h44 in the same cycle. PCSrc = 00, ALUResult = 32'h6, PCWrite = 1 -> PC = 6, pc_misaligned = 1, and it stays 1 until reset.
- Reset mid-instruction: assert reset between edges after a fetch -> PC, Instr, Data and fetch_count clear immediately without waiting for a clock edge.
